lsu_unit: RTL and testbench

- Load/store unit in the EX stage. Consumes the LSU request fields registered by the ID/EX pipeline register: lsu_req, lsu_we, lsu_operate, the ALU-computed address, rs2 data and rd.
- Runs a req/gnt/rvalid transaction on the data-memory port.
- Aligns store data and byte enables, and sign/zero-extends load data.
- Holds the pipeline stalled via lsu_busy_o until the access completes, then presents the writeback result.

---
 rtl/milano_pkg.sv | 27 ++
 rtl/lsu_unit_if.sv | 21 ++
 rtl/lsu_data_align.sv | 75 +++++++
 rtl/lsu_unit.sv | 115 +++++++++++
 tb/tb_lsu_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/milano_pkg.sv
// Shared types for the milano core: LSU operation encoding, LSU FSM states and helpers.
package milano_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LW   = 4'd3,
    LSU_LBU  = 4'd4,
    LSU_LHU  = 4'd5,
    LSU_SB   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SW   = 4'd8
  } lsu_opt_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic is_load(lsu_opt_e op);
    return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
           (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// Data-memory port: req/gnt request phase followed by an rvalid response phase.
interface lsu_unit_if;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store be/wdata, load extraction/extension, misalignment.
module lsu_data_align
  import milano_pkg::*;
#(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  lsu_opt_e    st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_al,
  output logic        misaligned,
  input  lsu_opt_e    ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  // Offsets below the access size are dropped so an unchecked access behaves as aligned.
  function automatic logic [1:0] eff_off(lsu_opt_e op, logic [1:0] off);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: return {off[1], 1'b0};
      LSU_LW, LSU_SW:          return 2'b00;
      default:                 return off;
    endcase
  endfunction

  logic [1:0]  s_off, l_off;
  logic [31:0] word;

  assign s_off = eff_off(st_op, st_off);
  assign l_off = eff_off(ld_op, ld_off);
  assign word  = ld_rdata >> {l_off, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    if (MISALIGN_CHECK) begin
      case (st_op)
        LSU_LH, LSU_LHU, LSU_SH: misaligned = st_off[0];
        LSU_LW, LSU_SW:          misaligned = (st_off != 2'b00);
        default:                 misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    st_be       = 4'b1111;
    st_wdata_al = st_wdata;
    case (st_op)
      LSU_SB: begin
        st_be       = 4'b0001 << s_off;
        st_wdata_al = {4{st_wdata[7:0]}};
      end
      LSU_SH: begin
        st_be       = 4'b0011 << s_off;
        st_wdata_al = {2{st_wdata[15:0]}};
      end
      LSU_NONE: st_be = 4'b0000;
      default:  st_be = 4'b1111;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (ld_op)
      LSU_LB:  ld_data = {{24{word[7]}}, word[7:0]};
      LSU_LBU: ld_data = {24'h0, word[7:0]};
      LSU_LH:  ld_data = {{16{word[15]}}, word[15:0]};
      LSU_LHU: ld_data = {16'h0, word[15:0]};
      LSU_LW:  ld_data = ld_rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// EX-stage load/store unit: one outstanding req/gnt/rvalid access, stalls the pipe until done.
module lsu_unit
  import milano_pkg::*;
#(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  lsu_opt_e    lsu_operate_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  rd_addr_i,
  lsu_unit_if.master  dbus,
  output logic        lsu_busy_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_wr_en_o,
  output logic        lsu_err_o
);

  lsu_state_e  state_q, state_d;
  logic        accept, mis;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  lsu_opt_e    op_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_al, ld_data;

  lsu_data_align #(.MISALIGN_CHECK(MISALIGN_CHECK)) u_align (
    .st_op      (lsu_operate_i),
    .st_off     (lsu_addr_i[1:0]),
    .st_wdata   (lsu_wdata_i),
    .st_be      (st_be),
    .st_wdata_al(st_wdata_al),
    .misaligned (mis),
    .ld_op      (op_q),
    .ld_off     (addr_q[1:0]),
    .ld_rdata   (dbus.data_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      LSU_IDLE: if (lsu_req_i && lsu_operate_i != LSU_NONE) begin
        accept = 1'b1;
        if (!mis) state_d = LSU_REQ;
      end
      LSU_REQ:  if (dbus.data_gnt)    state_d = LSU_WAIT;
      LSU_WAIT: if (dbus.data_rvalid) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Bus fields are only driven while the request is on the port; zero otherwise.
  always_comb begin
    dbus.data_req   = (state_q == LSU_REQ);
    dbus.data_addr  = dbus.data_req ? {addr_q[31:2], 2'b00} : 32'h0;
    dbus.data_we    = dbus.data_req & we_q;
    dbus.data_be    = dbus.data_req ? be_q : 4'b0000;
    dbus.data_wdata = dbus.data_req ? wdata_q : 32'h0;
  end

  assign lsu_busy_o = (accept && !mis) || (state_q != LSU_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      op_q         <= LSU_NONE;
      rd_q         <= '0;
      be_q         <= '0;
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= '0;
      rd_addr_o    <= '0;
      rd_wr_en_o   <= 1'b0;
      lsu_err_o    <= 1'b0;
    end else begin
      lsu_err_o    <= accept & mis;
      lsu_rvalid_o <= 1'b0;
      rd_wr_en_o   <= 1'b0;
      lsu_rdata_o  <= '0;
      rd_addr_o    <= '0;
      if (accept && !mis) begin
        addr_q  <= lsu_addr_i;
        wdata_q <= st_wdata_al;
        we_q    <= lsu_we_i;
        op_q    <= lsu_operate_i;
        rd_q    <= rd_addr_i;
        be_q    <= st_be;
      end
      if (state_q == LSU_WAIT && dbus.data_rvalid) begin
        lsu_rvalid_o <= 1'b1;
        if (is_load(op_q)) begin
          rd_wr_en_o  <= 1'b1;
          lsu_rdata_o <= ld_data;
          rd_addr_o   <= rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: stimulus pushes expected completions, a monitor pops and checks them.
module tb_lsu_unit;
  import milano_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  lsu_opt_e    lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [4:0]  rd_addr;
  logic        busy, rvalid_o, wr_en, err;
  logic [31:0] rdata_o;
  logic [4:0]  rd_o;

  lsu_unit_if dbus();

  lsu_unit #(.MISALIGN_CHECK(1'b1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .lsu_req_i    (lsu_req),
    .lsu_we_i     (lsu_we),
    .lsu_operate_i(lsu_op),
    .lsu_addr_i   (lsu_addr),
    .lsu_wdata_i  (lsu_wdata),
    .rd_addr_i    (rd_addr),
    .dbus         (dbus.master),
    .lsu_busy_o   (busy),
    .lsu_rvalid_o (rvalid_o),
    .lsu_rdata_o  (rdata_o),
    .rd_addr_o    (rd_o),
    .rd_wr_en_o   (wr_en),
    .lsu_err_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        wr_en;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pushed = 0;
  int   seen = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(logic e, logic w, logic [31:0] d, logic [4:0] r);
    exp_t x;
    x.err = e; x.wr_en = w; x.rdata = d; x.rd = r;
    exp_q.push_back(x);
    pushed++;
  endtask

  // Monitor: every completion or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (rvalid_o || err)) begin
      exp_t x;
      seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'h0, err, rvalid_o}, 32'h0);
      end else begin
        x = exp_q.pop_front();
        chk("mon_err", {31'h0, err}, {31'h0, x.err});
        chk("mon_rvalid", {31'h0, rvalid_o}, {31'h0, !x.err});
        chk("mon_wr_en", {31'h0, wr_en}, {31'h0, x.wr_en});
        if (x.wr_en) begin
          chk("mon_rdata", rdata_o, x.rdata);
          chk("mon_rd", {27'h0, rd_o}, {27'h0, x.rd});
        end
      end
    end
  end

  task automatic access(lsu_opt_e op, logic we, logic [31:0] addr, logic [31:0] wd,
                        logic [4:0] rd, int gnt_dly, logic [31:0] mem_rdata,
                        logic [31:0] exp_addr, logic [3:0] exp_be, logic [31:0] exp_wd,
                        logic [31:0] exp_ld);
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = we; lsu_op = op; lsu_addr = addr; lsu_wdata = wd; rd_addr = rd;
    #1 chk("busy_accept", {31'h0, busy}, 32'h1);
    push(1'b0, !we, exp_ld, rd);
    @(negedge clk);
    lsu_req = 1'b0; lsu_op = LSU_NONE; lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i <= gnt_dly; i++) begin
      chk("req", {31'h0, dbus.data_req}, 32'h1);
      chk("addr", dbus.data_addr, exp_addr);
      chk("be", {28'h0, dbus.data_be}, {28'h0, exp_be});
      chk("we", {31'h0, dbus.data_we}, {31'h0, we});
      if (we) chk("wdata", dbus.data_wdata, exp_wd);
      chk("busy_req", {31'h0, busy}, 32'h1);
      if (i == gnt_dly) dbus.data_gnt = 1'b1;
      @(negedge clk);
      dbus.data_gnt = 1'b0;
    end
    chk("req_drop", {31'h0, dbus.data_req}, 32'h0);
    chk("busy_wait", {31'h0, busy}, 32'h1);
    dbus.data_rvalid = 1'b1; dbus.data_rdata = mem_rdata;
    @(negedge clk);
    dbus.data_rvalid = 1'b0; dbus.data_rdata = 32'h0;
    chk("busy_done", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("single_pulse", {31'h0, rvalid_o}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_op = LSU_NONE;
    lsu_addr = '0; lsu_wdata = '0; rd_addr = '0;
    dbus.data_gnt = 1'b0; dbus.data_rvalid = 1'b0; dbus.data_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'h0, dbus.data_req}, 32'h0);
    chk("rst_be", {28'h0, dbus.data_be}, 32'h0);
    chk("rst_outs", {27'h0, busy, rvalid_o, wr_en, err, 1'b0}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    rst = 1'b0;

    //     op      we    addr          wdata         rd  gnt rdata        exp_addr      be       exp_wdata     exp_load
    access(LSU_LW,  1'b0, 32'h0000_0100, 32'h0,        5, 0, 32'hDEADBEEF, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEADBEEF);
    access(LSU_SB,  1'b1, 32'h0000_0203, 32'h0000_00A5, 9, 0, 32'h0,        32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    access(LSU_LB,  1'b0, 32'h0000_0002, 32'h0,        3, 0, 32'h0080_0000, 32'h0000_0000, 4'b1111, 32'h0,        32'hFFFF_FF80);
    access(LSU_LBU, 1'b0, 32'h0000_0002, 32'h0,        4, 0, 32'h0080_0000, 32'h0000_0000, 4'b1111, 32'h0,        32'h0000_0080);
    access(LSU_LH,  1'b0, 32'h0000_0002, 32'h0,        6, 0, 32'h8001_0000, 32'h0000_0000, 4'b1111, 32'h0,        32'hFFFF_8001);
    access(LSU_SW,  1'b1, 32'h0000_0300, 32'h1234_5678, 1, 4, 32'h0,        32'h0000_0300, 4'b1111, 32'h1234_5678, 32'h0);
    access(LSU_SH,  1'b1, 32'h0000_0106, 32'hABCD_1234, 2, 1, 32'h0,        32'h0000_0104, 4'b1100, 32'h1234_1234, 32'h0);

    // Misaligned word: error pulse only, no bus activity, no stall.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_op = LSU_LW; lsu_addr = 32'h0000_0102; rd_addr = 5'd8;
    #1 chk("busy_misalign", {31'h0, busy}, 32'h0);
    push(1'b1, 1'b0, 32'h0, 5'd0);
    @(negedge clk);
    lsu_req = 1'b0; lsu_op = LSU_NONE;
    chk("misalign_noreq", {31'h0, dbus.data_req}, 32'h0);
    chk("misalign_idle", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("misalign_noreq2", {31'h0, dbus.data_req}, 32'h0);

    access(LSU_LH,  1'b0, 32'h0000_0104, 32'h0,        7, 0, 32'h1234_F00D, 32'h0000_0104, 4'b1111, 32'h0,        32'hFFFF_F00D);
    access(LSU_LHU, 1'b0, 32'h0000_0106, 32'h0,       10, 2, 32'h7FFF_0000, 32'h0000_0104, 4'b1111, 32'h0,        32'h0000_7FFF);

    // Reset during WAIT_RVALID; the late rvalid must be dropped.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_op = LSU_LW; lsu_addr = 32'h0000_0400; rd_addr = 5'd11;
    @(negedge clk);
    lsu_req = 1'b0; lsu_op = LSU_NONE;
    dbus.data_gnt = 1'b1;
    @(negedge clk);
    dbus.data_gnt = 1'b0;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", {31'h0, dbus.data_req}, 32'h0);
    chk("mid_rst_outs", {27'h0, busy, rvalid_o, wr_en, err, 1'b0}, 32'h0);
    chk("mid_rst_addr", dbus.data_addr, 32'h0);
    dbus.data_rvalid = 1'b1; dbus.data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dbus.data_rvalid = 1'b0;
    chk("late_rvalid_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("late_rvalid_pulse", {31'h0, rvalid_o}, 32'h0);
    chk("late_rvalid_req", {31'h0, dbus.data_req}, 32'h0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    chk("pulse_count", seen, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
